fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write-side arbiter:
//   - arb_state_e : arbiter FSM states (IDLE = no grant, LOCK = grant held)
//   - DEF_NREQ    : default number of requesters
//   - DEF_WIDTH   : default beat width in bits
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin search. Finds the first asserted request
// starting one position after the previous winner, wrapping modulo NREQ.
// Ports:
//   req_i  [NREQ-1:0] : request vector
//   last_i [IDW-1:0]  : index of the previous winner
//   any_o             : at least one request is asserted
//   pick_o [IDW-1:0]  : index of the winner (0 when any_o is low)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic            any_o,
  output logic [IDW-1:0]  pick_o
);

  logic [IDW-1:0] idx;

  // Walk the candidates from farthest to nearest so the nearest valid
  // requester after last_i is written last and therefore wins.
  always_comb begin
    any_o  = |req_i;
    pick_o = '0;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(last_i) + k) % NREQ);
      if (req_i[idx]) begin
        pick_o = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter that lets NREQ requesters share one FIFO write port.
// An idle cycle is spent arbitrating, then the grant is held (LOCK) until a
// release beat is accepted.
//
// Build option: FIFO_WR_ARB_PKT_LOCK_EN
//   defined   : the grant is held until a beat with req_last is accepted
//   undefined : every accepted beat releases the grant; req_last is ignored
//
// Ports:
//   wr_clk, wr_rst_n : FIFO write clock, asynchronous active-low reset
//   req_valid/req_data/req_last : per-requester beat, data slice i at
//                                 [i*WIDTH +: WIDTH]
//   req_ready        : per-requester accept (only the granted one can be high)
//   fifo_wr_en/fifo_wr_data : FIFO write port
//   fifo_full        : FIFO full flag (registered in wr_clk)
//   grant_id         : currently / most recently granted requester
//   busy             : grant held
//   pkt_done         : one-cycle pulse the cycle after a grant is released
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fifo_wr_en,
  output logic [WIDTH-1:0]      fifo_wr_data,
  input  logic                  fifo_full,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic                  pkt_done
);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic           done_q, done_d;

  logic           pickAny;
  logic [IDW-1:0] pickIdx;
  logic           selValid;
  logic           accept;
  logic           releaseBeat;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
  logic           selLast;
`else
  logic           unusedLast;
  assign unusedLast = ^req_last;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) uPick (
    .req_i  (req_valid),
    .last_i (last_q),
    .any_o  (pickAny),
    .pick_o (pickIdx)
  );

  // Granted-requester mux, written as a decoded loop so every select uses a
  // constant index. Ready follows fifo_full with no latency so a full FIFO
  // can never be written.
  always_comb begin
    selValid     = 1'b0;
    fifo_wr_data = '0;
    req_ready    = '0;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    selLast      = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == IDW'(i)) begin
        selValid     = req_valid[i];
        fifo_wr_data = req_data[i*WIDTH +: WIDTH];
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
        selLast      = req_last[i];
`endif
        if (state_q == LOCK) begin
          req_ready[i] = ~fifo_full;
        end
      end
    end
    accept = (state_q == LOCK) & selValid & ~fifo_full;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    releaseBeat = accept & selLast;
`else
    releaseBeat = accept;
`endif
  end

  assign fifo_wr_en = accept;
  assign grant_id   = grant_q;
  assign busy       = (state_q == LOCK);
  assign pkt_done   = done_q;

  // Next-state logic: IDLE registers the round-robin pick, LOCK waits
  // (through stalls and valid gaps) for the release beat.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pickAny) begin
          grant_d = pickIdx;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (releaseBeat) begin
          last_d  = grant_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to NREQ-1 so requester 0 has top priority after reset.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ - 1);
      grant_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

endmodule
